// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Used by gshare_predictor_v2 and its pattern history table.
package bp_pkg;

  typedef enum logic [1:0] {
    PC_IF_PLUS4  = 2'b00,
    PC_EX_PLUS4  = 2'b01,
    PC_BTB       = 2'b10,
    PC_EX_TARGET = 2'b11
  } pcnext_sel_e;

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic        is_cond;
  } btb_entry_t;

  // Bit i of the history lands on index bit i % iw, which XORs the chunks.
  function automatic logic [31:0] fold_history(
    input logic [63:0] h,
    input int          hw,
    input int          iw
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < hw) begin
        r[5'(i % iw)] = r[5'(i % iw)] ^ h[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table of saturating counters.
// Asynchronous read, synchronous +/-1 update.
module gshare_pht #(
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int CTR_WIDTH       = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PHT_INDEX_WIDTH-1:0] rd_idx,
  output logic [CTR_WIDTH-1:0]       rd_ctr,
  input  logic                       upd_en,
  input  logic [PHT_INDEX_WIDTH-1:0] upd_idx,
  input  logic                       upd_taken
);

  localparam int ENTRIES = 1 << PHT_INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
  logic [CTR_WIDTH-1:0] cur;

  assign rd_ctr = ctr_q[rd_idx];
  assign cur    = ctr_q[upd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (upd_en) begin
      if (upd_taken && cur != CTR_MAX) begin
        ctr_q[upd_idx] <= cur + 1'b1;
      end else if (!upd_taken && cur != '0) begin
        ctr_q[upd_idx] <= cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/gshare_predictor_v2.sv
// Gshare predictor with BTB and checkpointed GHR recovery at EXMEM.
// Define GSHARE_PERF_EN to add lookup/mispredict performance counters.
module gshare_predictor_v2
  import bp_pkg::*;
#(
  parameter int BTB_INDEX_WIDTH = 6,
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int HISTORY_WIDTH   = 12,
  parameter int CTR_WIDTH       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              IF_pc_i,
  input  logic                     IF_valid_i,
  input  logic                     IF_stall_i,
  input  logic                     EXMEM_valid_i,
  input  logic [31:0]              EXMEM_pc_i,
  input  logic                     EXMEM_is_br_i,
  input  logic                     EXMEM_is_jmp_i,
  input  logic                     EXMEM_taken_i,
  input  logic [31:0]              EXMEM_target_i,
  input  logic                     EXMEM_prediction_i,
  input  logic [31:0]              EXMEM_pred_target_i,
  input  logic [HISTORY_WIDTH-1:0] EXMEM_ghr_i,
  output logic                     IF_hit_o,
  output logic                     IF_prediction_o,
  output logic [31:0]              IF_target_o,
  output logic [HISTORY_WIDTH-1:0] IF_ghr_o,
  output logic [1:0]               IF_PCnext_sel_o,
  output logic                     IF_flush_o
`ifdef GSHARE_PERF_EN
  ,
  output logic [31:0]              perf_lookups_o,
  output logic [31:0]              perf_mispred_o
`endif
);

  localparam int BIW = BTB_INDEX_WIDTH;
  localparam int PIW = PHT_INDEX_WIDTH;
  localparam int HW  = HISTORY_WIDTH;
  localparam int BTB_ENTRIES = 1 << BIW;

  btb_entry_t btb_q [BTB_ENTRIES];
  logic [HW-1:0] ghr_q, ghr_d;

  logic [BIW-1:0] if_bidx, ex_bidx;
  logic [29:0]    if_tag, ex_tag;
  btb_entry_t     if_ent, ex_ent;
  logic           if_hit, ex_hit;
  logic [31:0]    if_fold, ex_fold;
  logic [PIW-1:0] if_pidx, ex_pidx;
  logic [CTR_WIDTH-1:0] if_ctr;

  assign if_bidx = IF_pc_i[BIW+1:2];
  assign if_tag  = 30'(IF_pc_i[31:BIW+2]);
  assign if_ent  = btb_q[if_bidx];
  assign if_hit  = if_ent.valid && (if_ent.tag == if_tag);
  assign if_fold = fold_history(64'(ghr_q), HW, PIW);
  assign if_pidx = IF_pc_i[PIW+1:2] ^ if_fold[PIW-1:0];

  assign ex_bidx = EXMEM_pc_i[BIW+1:2];
  assign ex_tag  = 30'(EXMEM_pc_i[31:BIW+2]);
  assign ex_ent  = btb_q[ex_bidx];
  assign ex_hit  = ex_ent.valid && (ex_ent.tag == ex_tag);
  assign ex_fold = fold_history(64'(EXMEM_ghr_i), HW, PIW);
  assign ex_pidx = EXMEM_pc_i[PIW+1:2] ^ ex_fold[PIW-1:0];

  gshare_pht #(
    .PHT_INDEX_WIDTH(PIW),
    .CTR_WIDTH      (CTR_WIDTH)
  ) u_pht (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (if_pidx),
    .rd_ctr   (if_ctr),
    .upd_en   (EXMEM_valid_i & EXMEM_is_br_i),
    .upd_idx  (ex_pidx),
    .upd_taken(EXMEM_taken_i)
  );

  assign IF_hit_o        = if_hit;
  assign IF_prediction_o = if_hit &
    (if_ent.is_cond ? if_ctr[CTR_WIDTH-1] : 1'b1);
  assign IF_target_o     = if_ent.target;
  assign IF_ghr_o        = ghr_q;

  logic ex_cti, dir_miss, tgt_miss, alias_miss, mispredict;
  logic fetch_shift, btb_wr, btb_clr;

  assign ex_cti     = EXMEM_is_br_i | EXMEM_is_jmp_i;
  assign dir_miss   = ex_cti & (EXMEM_prediction_i != EXMEM_taken_i);
  assign tgt_miss   = ex_cti & EXMEM_prediction_i & EXMEM_taken_i &
                      (EXMEM_pred_target_i != EXMEM_target_i);
  assign alias_miss = ~ex_cti & EXMEM_prediction_i;
  assign mispredict = EXMEM_valid_i & (dir_miss | tgt_miss | alias_miss);

  assign fetch_shift = IF_valid_i & ~IF_stall_i & if_hit & if_ent.is_cond;
  assign btb_wr  = EXMEM_valid_i & ex_cti & EXMEM_taken_i &
                   (~ex_hit | (ex_ent.target != EXMEM_target_i));
  assign btb_clr = mispredict & ~ex_cti;

  pcnext_sel_e sel;

  always_comb begin
    sel        = PC_IF_PLUS4;
    IF_flush_o = 1'b0;
    if (rst_i) begin
      sel        = PC_IF_PLUS4;
      IF_flush_o = 1'b0;
    end else if (mispredict) begin
      IF_flush_o = 1'b1;
      sel = EXMEM_taken_i ? PC_EX_TARGET : PC_EX_PLUS4;
    end else if (IF_prediction_o) begin
      sel = PC_BTB;
    end
  end

  assign IF_PCnext_sel_o = sel;

  // Commit-stage recovery overrides any speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = EXMEM_is_br_i ?
        ((EXMEM_ghr_i << 1) | HW'(EXMEM_taken_i)) : EXMEM_ghr_i;
    end else if (fetch_shift) begin
      ghr_d = (ghr_q << 1) | HW'(IF_prediction_o);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
      end
    end else begin
      ghr_q <= ghr_d;
      if (btb_wr) begin
        btb_q[ex_bidx] <= '{valid:   1'b1,
                            tag:     ex_tag,
                            target:  EXMEM_target_i,
                            is_cond: EXMEM_is_br_i};
      end else if (btb_clr) begin
        btb_q[ex_bidx].valid <= 1'b0;
      end
    end
  end

`ifdef GSHARE_PERF_EN
  logic [31:0] lookups_q, mispred_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (IF_valid_i & ~IF_stall_i & if_hit) lookups_q <= lookups_q + 1'b1;
      if (mispredict) mispred_q <= mispred_q + 1'b1;
    end
  end

  assign perf_lookups_o = lookups_q;
  assign perf_mispred_o = mispred_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{IF_pc_i[1:0], EXMEM_pc_i[1:0],
                         if_fold, ex_fold, ex_ent.is_cond};

endmodule

// File: tb/tb_gshare_predictor_v2.sv
// Directed bench for gshare_predictor_v2 with a cycle-level reference model.
// Builds with or without GSHARE_PERF_EN.
module tb_gshare_predictor_v2;

  localparam int H = 12;
  localparam int P = 10;
  localparam int NB = 64;
  localparam int NP = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] if_pc;
  logic        if_valid, if_stall;
  logic        ex_valid, ex_br, ex_jmp, ex_taken, ex_pred;
  logic [31:0] ex_pc, ex_tgt, ex_ptgt;
  logic [H-1:0] ex_ghr;

  logic        hit, pred, flush;
  logic [31:0] tgt;
  logic [H-1:0] ghr;
  logic [1:0]  sel;
`ifdef GSHARE_PERF_EN
  logic [31:0] perf_lk, perf_mp;
`endif

  gshare_predictor_v2 dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .IF_pc_i            (if_pc),
    .IF_valid_i         (if_valid),
    .IF_stall_i         (if_stall),
    .EXMEM_valid_i      (ex_valid),
    .EXMEM_pc_i         (ex_pc),
    .EXMEM_is_br_i      (ex_br),
    .EXMEM_is_jmp_i     (ex_jmp),
    .EXMEM_taken_i      (ex_taken),
    .EXMEM_target_i     (ex_tgt),
    .EXMEM_prediction_i (ex_pred),
    .EXMEM_pred_target_i(ex_ptgt),
    .EXMEM_ghr_i        (ex_ghr),
    .IF_hit_o           (hit),
    .IF_prediction_o    (pred),
    .IF_target_o        (tgt),
    .IF_ghr_o           (ghr),
    .IF_PCnext_sel_o    (sel),
    .IF_flush_o         (flush)
`ifdef GSHARE_PERF_EN
    ,
    .perf_lookups_o     (perf_lk),
    .perf_mispred_o     (perf_mp)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  bit          m_val  [NB];
  int unsigned m_tag  [NB];
  int unsigned m_tgt  [NB];
  bit          m_cond [NB];
  int          m_pht  [NP];
  int unsigned m_ghr;
  int unsigned m_lk, m_mp;
  bit          cmp_en = 0;

  function automatic int fold(input int unsigned h);
    int r;
    r = 0;
    for (int i = 0; i < H; i++) if (h[i]) r = r ^ (1 << (i % P));
    return r;
  endfunction

  function automatic int bidx(input int unsigned pc);
    return int'((pc >> 2) % NB);
  endfunction

  function automatic int pidx(input int unsigned pc, input int unsigned g);
    return int'((pc >> 2) % NP) ^ fold(g);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_val[bidx(pc)] && (m_tag[bidx(pc)] == (pc >> 8));
  endfunction

  function automatic bit m_pred(input int unsigned pc);
    if (!m_hit(pc)) return 0;
    if (!m_cond[bidx(pc)]) return 1;
    return m_pht[pidx(pc, m_ghr)] >= 2;
  endfunction

  function automatic bit m_misp();
    bit cti;
    cti = ex_br || ex_jmp;
    if (!ex_valid) return 0;
    if (cti && ex_pred != ex_taken) return 1;
    if (cti && ex_pred && ex_taken && ex_ptgt != ex_tgt) return 1;
    if (!cti && ex_pred) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit mp, pr, h, eh;
    int bi, ebi, epi;
    if (rst) begin
      m_ghr = 0;
      m_lk = 0;
      m_mp = 0;
      foreach (m_val[i]) m_val[i] = 0;
      foreach (m_pht[i]) m_pht[i] = 1;
    end else begin
      mp = m_misp();
      h = m_hit(if_pc);
      pr = m_pred(if_pc);
      bi = bidx(if_pc);
      ebi = bidx(ex_pc);
      eh = m_hit(ex_pc);
      if (if_valid && !if_stall && h) m_lk++;
      if (mp) m_mp++;
      if (ex_valid && ex_br) begin
        epi = pidx(ex_pc, ex_ghr);
        if (ex_taken) m_pht[epi] = (m_pht[epi] < 3) ? m_pht[epi] + 1 : 3;
        else m_pht[epi] = (m_pht[epi] > 0) ? m_pht[epi] - 1 : 0;
      end
      if (mp)
        m_ghr = ex_br ? (((ex_ghr << 1) | ex_taken) & 'hFFF) : ex_ghr;
      else if (if_valid && !if_stall && h && m_cond[bi])
        m_ghr = ((m_ghr << 1) | pr) & 'hFFF;
      if (ex_valid && (ex_br || ex_jmp) && ex_taken &&
          (!eh || m_tgt[ebi] != ex_tgt)) begin
        m_val[ebi] = 1;
        m_tag[ebi] = ex_pc >> 8;
        m_tgt[ebi] = ex_tgt;
        m_cond[ebi] = ex_br;
      end else if (mp && !ex_br && !ex_jmp) begin
        m_val[ebi] = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit mp, pr;
    int es;
    bit ef;
    if (cmp_en) begin
      mp = m_misp();
      pr = m_pred(if_pc);
      if (rst) begin
        es = 0; ef = 0;
      end else if (mp) begin
        ef = 1; es = ex_taken ? 3 : 1;
      end else begin
        ef = 0; es = pr ? 2 : 0;
      end
      chk("m_hit", hit, m_hit(if_pc));
      chk("m_pred", pred, pr);
      chk("m_sel", sel, es);
      chk("m_flush", flush, ef);
      chk("m_ghr", ghr, m_ghr);
      if (m_hit(if_pc)) chk("m_target", tgt, m_tgt[bidx(if_pc)]);
`ifdef GSHARE_PERF_EN
      chk("m_perf_lookups", perf_lk, m_lk);
      chk("m_perf_mispred", perf_mp, m_mp);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_br = 0; ex_jmp = 0; ex_taken = 0; ex_pred = 0;
    ex_pc = 0; ex_tgt = 0; ex_ptgt = 0; ex_ghr = 0;
  endtask

  task automatic commit(input bit br, input bit jmp, input bit tk,
                        input bit pr, input logic [31:0] pc,
                        input logic [31:0] t, input logic [31:0] pt,
                        input logic [H-1:0] g);
    ex_valid = 1; ex_br = br; ex_jmp = jmp; ex_taken = tk; ex_pred = pr;
    ex_pc = pc; ex_tgt = t; ex_ptgt = pt; ex_ghr = g;
  endtask

  initial begin
    rst = 1; if_pc = 0; if_valid = 0; if_stall = 0;
    ex_idle();
    tick();
    cmp_en = 1;
    // alias mispredict presented while reset is held must not redirect
    commit(0, 0, 0, 1, 32'h100, 0, 0, 0);
    @(negedge clk);
    chk("rst_flush", flush, 0);
    chk("rst_sel", sel, 0);
    tick();

    rst = 0; ex_idle(); if_pc = 32'h100; if_valid = 1;
    @(negedge clk);
    chk("t1_hit", hit, 0);
    chk("t1_pred", pred, 0);
    chk("t1_sel", sel, 0);
    chk("t1_ghr", ghr, 0);
    tick();

    if_stall = 1;
    commit(1, 0, 1, 0, 32'h100, 32'h200, 0, 12'h000);
    @(negedge clk);
    chk("t2_flush", flush, 1);
    chk("t2_sel", sel, 3);
    tick();
    ex_idle();
    @(negedge clk);
    chk("t2_ghr", ghr, 12'h001);
    chk("t2_hit", hit, 1);
    chk("t2_target", tgt, 32'h200);
    tick();

    for (int i = 0; i < 2; i++) begin
      commit(1, 0, 1, 1, 32'h100, 32'h200, 32'h200, 12'h001);
      @(negedge clk);
      chk("t3_train_flush", flush, 0);
      tick();
    end
    ex_idle();
    @(negedge clk);
    chk("t3_pred_taken", pred, 1);
    chk("t3_sel_btb", sel, 2);
    tick();
    for (int i = 0; i < 2; i++) begin
      commit(1, 0, 0, 0, 32'h100, 32'h200, 0, 12'h001);
      tick();
    end
    ex_idle();
    @(negedge clk);
    chk("t3_pred_nt", pred, 0);
    chk("t3_sel_nt", sel, 0);
    tick();

    commit(0, 1, 1, 0, 32'h404, 32'h500, 0, 12'h005);
    @(negedge clk);
    chk("t4_jal_sel", sel, 3);
    tick();
    for (int i = 0; i < 2; i++) begin
      commit(1, 0, 1, 1, 32'h100, 32'h200, 32'h200, 12'h005);
      tick();
    end
    ex_idle(); if_stall = 0;
    @(negedge clk);
    chk("t4_ghr5", ghr, 12'h005);
    chk("t4_pred", pred, 1);
    tick();
    commit(1, 0, 0, 1, 32'h100, 32'h200, 32'h200, 12'h005);
    @(negedge clk);
    chk("t4_ghrB", ghr, 12'h00B);
    chk("t4_sel", sel, 1);
    chk("t4_flush", flush, 1);
    tick();
    ex_idle(); if_stall = 1;
    @(negedge clk);
    chk("t4_ghrA", ghr, 12'h00A);
    tick();

    commit(0, 1, 1, 0, 32'h408, 32'h300, 0, 12'h00A);
    tick();
    commit(0, 1, 1, 1, 32'h408, 32'h340, 32'h300, 12'h003);
    @(negedge clk);
    chk("t5_flush", flush, 1);
    chk("t5_sel", sel, 3);
    tick();
    ex_idle(); if_pc = 32'h408;
    @(negedge clk);
    chk("t5_ghr", ghr, 12'h003);
    chk("t5_hit", hit, 1);
    chk("t5_target", tgt, 32'h340);
    chk("t5_sel", sel, 2);
    tick();

    commit(0, 0, 0, 1, 32'h408, 0, 0, 12'h007);
    @(negedge clk);
    chk("t6_sel", sel, 1);
    chk("t6_flush", flush, 1);
    tick();
    ex_idle();
    @(negedge clk);
    chk("t6_hit_cleared", hit, 0);
    chk("t6_ghr", ghr, 12'h007);
`ifdef GSHARE_PERF_EN
    chk("t6_perf_mispred", perf_mp, 6);
`endif
    tick();

    // not-taken branch that misses the BTB must not allocate
    commit(1, 0, 0, 0, 32'h40C, 32'h600, 0, 12'h007);
    tick();
    ex_idle(); if_pc = 32'h40C;
    @(negedge clk);
    chk("nt_no_alloc", hit, 0);
    tick();

    // free-running fetch mix, checked by the model each cycle
    if_stall = 0;
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: if_pc = 32'h100;
        1: if_pc = 32'h404;
        2: if_pc = 32'h408;
        default: if_pc = 32'h100;
      endcase
      if_valid = (i % 5) != 3;
      if_stall = (i % 7) == 2;
      if (i % 6 == 1) commit(1, 0, i[1], 0, 32'h100, 32'h200, 0, ghr);
      else ex_idle();
      tick();
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
